// File: rtl/mac_acc_pair.sv
// mac_acc_pair: signed multiply-accumulate over ACC_LEN-term windows.
// Two independently valid operand streams are paired through one-deep
// holding slots with ready backpressure; each window result is emitted
// with a single-cycle out_valid pulse.
// Optional build macro: MAC_SAT_EN enables per-step saturation with a
// sticky per-window flag reported on out_sat.
`timescale 1ns/1ps

module mac_acc_pair #(
    parameter  int unsigned IN_W    = 4,
    parameter  int unsigned ACC_LEN = 8,
    parameter  int unsigned OUT_W   = 11,
    localparam int unsigned CNT_W   = $clog2(ACC_LEN) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  in_a,
    input  logic                    in_valid_a,
    output logic                    in_ready_a,
    input  logic signed [IN_W-1:0]  in_b,
    input  logic                    in_valid_b,
    output logic                    in_ready_b,
    input  logic                    clear,
    output logic signed [OUT_W-1:0] mac_out,
    output logic                    out_valid,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        cnt
);

    localparam int unsigned PROD_W = 2 * IN_W;

    logic                    have_a;
    logic                    have_b;
    logic signed [IN_W-1:0]  hold_a;
    logic signed [IN_W-1:0]  hold_b;
    logic signed [OUT_W-1:0] acc;

    logic                    fire;
    logic                    accept_a;
    logic                    accept_b;
    logic                    last;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0] prod_ext;
    logic signed [OUT_W-1:0] sum;
`ifdef MAC_SAT_EN
    logic signed [OUT_W:0]   sum_wide;
    logic                    sat_step;
    logic                    sat_flag;
`endif

    // Handshake, pairing and next accumulator value
    always_comb begin
        fire       = have_a & have_b;
        in_ready_a = ~reset & (~have_a | fire);
        in_ready_b = ~reset & (~have_b | fire);
        accept_a   = in_valid_a & in_ready_a;
        accept_b   = in_valid_b & in_ready_b;
        last       = fire & (cnt == CNT_W'(ACC_LEN - 1));
        prod       = PROD_W'(hold_a) * PROD_W'(hold_b);
        prod_ext   = OUT_W'(prod);
`ifdef MAC_SAT_EN
        sum_wide = (OUT_W + 1)'(acc) + (OUT_W + 1)'(prod_ext);
        sat_step = sum_wide[OUT_W] ^ sum_wide[OUT_W-1];
        if (sat_step) begin
            sum = sum_wide[OUT_W] ? {1'b1, {(OUT_W - 1){1'b0}}}
                                  : {1'b0, {(OUT_W - 1){1'b1}}};
        end else begin
            sum = sum_wide[OUT_W-1:0];
        end
`else
        sum = acc + prod_ext;
`endif
    end

    // Holding slots, accumulator, window counter and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            have_a    <= 1'b0;
            have_b    <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            acc       <= '0;
            cnt       <= '0;
            mac_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                have_a <= 1'b0;
                have_b <= 1'b0;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                have_a <= accept_a | (have_a & ~fire);
                have_b <= accept_b | (have_b & ~fire);
                if (accept_a) hold_a <= in_a;
                if (accept_b) hold_b <= in_b;
                if (fire) begin
                    if (last) begin
                        mac_out   <= sum;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef MAC_SAT_EN
    // Sticky clamp flag per window, published alongside each result
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag <= 1'b0;
            out_sat  <= 1'b0;
        end else if (clear) begin
            sat_flag <= 1'b0;
        end else if (fire) begin
            if (last) begin
                out_sat  <= sat_flag | sat_step;
                sat_flag <= 1'b0;
            end else begin
                sat_flag <= sat_flag | sat_step;
            end
        end
    end
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_mac_acc_pair.sv
// Directed bench for mac_acc_pair: default instance plus an OUT_W=8
// instance for the wrap/saturation boundary (expectations follow MAC_SAT_EN).
`timescale 1ns/1ps

module tb_mac_acc_pair;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               clear;
    logic signed [3:0]  in_a, in_b, in_a2, in_b2;
    logic               in_valid_a, in_valid_b, in_valid_a2, in_valid_b2;
    logic               in_ready_a, in_ready_b, in_ready_a2, in_ready_b2;
    logic signed [10:0] mac_out;
    logic signed [7:0]  mac_out2;
    logic               out_valid, out_sat, out_valid2, out_sat2;
    logic [3:0]         cnt, cnt2;

    int vectors     = 0;
    int miscompares = 0;

    int                 pulses;
    int                 pulse_at;
    logic signed [10:0] pulse_val;
    logic               ready_ok;

    mac_acc_pair dut (
        .clk(clk), .reset(reset),
        .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a),
        .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b),
        .clear(clear), .mac_out(mac_out), .out_valid(out_valid),
        .out_sat(out_sat), .cnt(cnt)
    );

    mac_acc_pair #(.IN_W(4), .ACC_LEN(8), .OUT_W(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_a(in_a2), .in_valid_a(in_valid_a2), .in_ready_a(in_ready_a2),
        .in_b(in_b2), .in_valid_b(in_valid_b2), .in_ready_b(in_ready_b2),
        .clear(clear), .mac_out(mac_out2), .out_valid(out_valid2),
        .out_sat(out_sat2), .cnt(cnt2)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // n full-rate pairs on the default instance, one per cycle
    task automatic send(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) begin
            in_a       = 4'(a);
            in_b       = 4'(b);
            in_valid_a = 1'b1;
            in_valid_b = 1'b1;
            tick();
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic send8(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) begin
            in_a2       = 4'(a);
            in_b2       = 4'(b);
            in_valid_a2 = 1'b1;
            in_valid_b2 = 1'b1;
            tick();
        end
        in_valid_a2 = 1'b0;
        in_valid_b2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        in_a = '0; in_b = '0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_a2 = '0; in_b2 = '0; in_valid_a2 = 1'b0; in_valid_b2 = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_ready_a", in_ready_a, 0);
        chk("rst_ready_b", in_ready_b, 0);
        chk("rst_mac_out", mac_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_out_sat", out_sat, 0);
        reset = 1'b0;
        tick();
        chk("rel_ready_a", in_ready_a, 1);

        // 8 pairs of -8*-8 at full rate
        send(8, -8, -8);
        chk("t1_no_early", out_valid, 0);
        chk("t1_cnt7", cnt, 7);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_mac", mac_out, 512);
        chk("t1_cnt0", cnt, 0);
        chk("t1_sat", out_sat, 0);
        tick();
        chk("t1_pulse_end", out_valid, 0);
        chk("t1_hold", mac_out, 512);

        // a=3 waits three cycles for b=-2; a second a stalls behind it
        in_a = 4'sd3; in_valid_a = 1'b1;
        tick();
        chk("t2_wait_a", in_ready_a, 0);
        tick();
        chk("t2_wait_a2", in_ready_a, 0);
        chk("t2_ready_b", in_ready_b, 1);
        tick();
        in_b = -4'sd2; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        chk("t2_cnt_before_fire", cnt, 0);
        chk("t2_ready_on_fire", in_ready_a, 1);
        tick();
        in_valid_a = 1'b0;
        chk("t2_cnt1", cnt, 1);
        chk("t2_second_a_held", in_ready_a, 0);
        in_b = -4'sd2; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        tick();
        chk("t2_cnt2", cnt, 2);
        send(6, 3, -2);
        chk("t2_no_early", out_valid, 0);
        tick();
        chk("t2_valid", out_valid, 1);
        chk("t2_mac", mac_out, -48);

        // 16 back-to-back pairs spanning two windows
        pulses = 0; pulse_at = -1; pulse_val = '0; ready_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_a = (i < 8) ? 4'sd1 : -4'sd1;
            in_b = (i < 8) ? 4'sd1 : 4'sd2;
            in_valid_a = 1'b1;
            in_valid_b = 1'b1;
            if (!(in_ready_a && in_ready_b)) ready_ok = 1'b0;
            tick();
            if (out_valid) begin
                pulses++;
                pulse_at  = i;
                pulse_val = mac_out;
            end
        end
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        chk("t3_ready_steady", ready_ok, 1);
        chk("t3_pulses_in_run", pulses, 1);
        chk("t3_pulse_pos", pulse_at, 8);
        chk("t3_mac_first", pulse_val, 8);
        tick();
        chk("t3_valid_second", out_valid, 1);
        chk("t3_mac_second", mac_out, -16);

        // clear mid-window, coinciding with a fire and a new accept
        tick();
        send(5, 7, 7);
        chk("t4_cnt4", cnt, 4);
        clear = 1'b1;
        in_a = 4'sd7; in_b = 4'sd7; in_valid_a = 1'b1; in_valid_b = 1'b1;
        tick();
        clear = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        chk("t4_cnt_cleared", cnt, 0);
        chk("t4_mac_kept", mac_out, -16);
        chk("t4_no_valid", out_valid, 0);
        chk("t4_slot_empty", in_ready_a, 1);
        send(8, 1, 1);
        tick();
        chk("t4_valid", out_valid, 1);
        chk("t4_mac", mac_out, 8);

        // reset mid-window
        tick();
        send(4, 5, 5);
        reset = 1'b1;
        tick();
        chk("t5_mac", mac_out, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_cnt", cnt, 0);
        chk("t5_ready_a", in_ready_a, 0);
        chk("t5_ready_b", in_ready_b, 0);
        reset = 1'b0;
        #1;
        chk("t5_ready_rel", in_ready_a, 1);
        tick();
        send(8, 2, 2);
        tick();
        chk("t5_valid_after", out_valid, 1);
        chk("t5_mac_after", mac_out, 32);

        // OUT_W=8 boundary: 8 * 49 = 392 overflows the result range
        send8(8, 7, 7);
        tick();
        chk("t6_valid", out_valid2, 1);
`ifdef MAC_SAT_EN
        chk("t6_mac_sat", mac_out2, 127);
        chk("t6_out_sat", out_sat2, 1);
`else
        chk("t6_mac_wrap", mac_out2, -120);
        chk("t6_out_sat", out_sat2, 0);
`endif
        send8(8, 1, 1);
        tick();
        chk("t6_valid_next", out_valid2, 1);
        chk("t6_mac_next", mac_out2, 8);
        chk("t6_sat_next", out_sat2, 0);
        chk("t6_main_sat", out_sat, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_acc_pair.md
Name: mac_acc_pair

Overview:
Parametrised signed multiply-accumulate block, the successor to the fixed 4-bit, 8-term MAC. It takes two independently valid operand streams and pairs them through one-deep holding registers with ready backpressure. It sums ACC_LEN products per window and emits each result with a one-cycle out_valid pulse. It sits between the operand sources and the result collector in the MAC datapath, and adds a clear input and optional saturation.

Parameters:
IN_W, 4, operand width (signed two's complement), >= 2
ACC_LEN, 8, products per accumulation window, >= 1
OUT_W, 11, accumulator/result width, >= 2*IN_W
CNT_W, $clog2(ACC_LEN)+1, window counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-high reset
in_a  input  IN_W  signed operand A
in_valid_a  input  1  A valid
in_ready_a  output  1  A holding slot can accept
in_b  input  IN_W  signed operand B
in_valid_b  input  1  B valid
in_ready_b  output  1  B holding slot can accept
clear  input  1  synchronous abort of current window
mac_out  output  OUT_W  signed window result, held until next result
out_valid  output  1  one-cycle pulse, mac_out updated
out_sat  output  1  window saturated (MAC_SAT_EN only, else 0)
cnt  output  CNT_W  products accumulated in current window

Behaviour:
- Reset (sampled at clk edge while reset=1): have_a=have_b=0, acc=0, cnt=0, mac_out=0, out_valid=0, out_sat=0.
- in_ready_a/in_ready_b are forced 0 while reset=1.
- Holding: have_x set when in_valid_x & in_ready_x, and hold_x <= in_x.
- in_ready_x = !have_x | fire, where fire = have_a & have_b (registered flags). This allows one pair per cycle at full rate.
- Fire consumes both slots. A same-cycle new accept refills a slot; otherwise it clears.
- Independent arrival: an operand waits in its slot with in_ready low until its partner arrives. Pairing is strictly in arrival order.
- On fire: prod = hold_a*hold_b as a 2*IN_W signed value, sign-extended to OUT_W. Then sum = acc + prod, and cnt increments.
- Last term (fire & cnt==ACC_LEN-1): mac_out <= sum, out_valid <= 1 next cycle, acc <= 0, cnt <= 0.
- Latency: input accepted at edge t, fire in cycle t+1. The last fire's result is visible at t+2.
- Arithmetic without the optional feature wraps modulo 2^OUT_W.
- out_valid is 0 in every cycle without a last-term fire. mac_out holds its value between results.
- clear=1: acc, cnt, have_a and have_b are zeroed and out_valid is 0 next cycle. mac_out is unchanged.
- clear overrides a simultaneous fire or accept. in_ready_x is still computed normally during clear, but the accepted data is discarded.
- ACC_LEN=1: every fire produces a result.
- Reset mid-window discards all partial state identically to reset.

Optional Feature:
MAC_SAT_EN defined: each accumulate step clamps sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A sticky window flag records any clamp. out_sat <= flag together with out_valid, and the flag clears at window end, on clear and on reset.
MAC_SAT_EN undefined: wrap arithmetic; out_sat tied 0 and no flag register.

Test Plan:
- Defaults; 8 simultaneous pairs a=b=-8 at full rate -> single out_valid pulse 2 cycles after last accept, mac_out=512, cnt returns 0.
- a=3 presented 3 cycles before b=-2 -> in_ready_a=0 while waiting. A second a is stalled and not lost. Product -6 is accumulated once; 8 such pairs -> mac_out=-48.
- 16 back-to-back pairs (first 8: a=1,b=1; next 8: a=-1,b=2) -> pulses exactly 8 cycles apart, mac_out=8 then -16; ready stays 1 throughout.
- 5 pairs of 7*7, then clear, then 8 pairs of 1*1 -> only result is 8. mac_out keeps the prior value across the clear; clear coinciding with a fire drops that pair.
- reset asserted after 4 pairs -> all outputs 0 next cycle and in_ready=0 while reset is high. After release, ready=1 and a fresh 8-pair window of 2*2 -> 32.
- OUT_W=8, 8 pairs 7*7 -> without MAC_SAT_EN mac_out=-120 and out_sat=0; with MAC_SAT_EN mac_out=127 and out_sat=1 for one result only.
